rps_round_controller: RTL

Sequencer for one rock-paper-scissors round. It debounces the start key and selects the computer choice from the random, Markov or reinforcement player according to mode. It then latches both choices, scores the round, and hands off to the VGA drawer, holding off further rounds until the drawing completes. It sits between the key/switch inputs, the three computer players, the score HEX displays/LEDs and the screen drawer.

---
 rtl/rps_round_controller.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/rps_round_controller.sv
// Rock-paper-scissors round sequencer: debounced start key, computer-choice select,
// scoring with saturating counters, and hand-off to the screen drawer.
module rps_round_controller #(
   parameter int DEBOUNCE      = 500000,
   parameter int READY_TIMEOUT = 1024
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       start_n,
   input  logic [1:0] mode,
   input  logic [1:0] user,
   input  logic [1:0] com_ra,
   input  logic [1:0] com_m,
   input  logic [1:0] com_re,
   input  logic       re_ready,
   input  logic       draw_done,
   output logic [1:0] com_loaded,
   output logic [1:0] user_loaded,
   output logic [7:0] user_score,
   output logic [7:0] com_score,
   output logic       uwin,
   output logic       cwin,
   output logic       equ,
   output logic       learn_valid,
   output logic       draw_start,
   output logic       fallback,
   output logic       invalid_press,
   output logic       busy
);
   localparam int DB_W = $clog2(DEBOUNCE + 1);
   localparam int TO_W = $clog2(READY_TIMEOUT + 1);

   localparam logic [2:0] IDLE       = 3'd0;
   localparam logic [2:0] WAIT_READY = 3'd1;
   localparam logic [2:0] LATCH      = 3'd2;
   localparam logic [2:0] SCORE      = 3'd3;
   localparam logic [2:0] WAIT_DRAW  = 3'd4;

   logic [2:0]      state;
   logic            key_s1, key_s2, key_db;
   logic [DB_W-1:0] db_cnt;
   logic [TO_W-1:0] to_cnt;
   logic            press;
   logic [1:0]      user_h, mode_h, com_raw, com_sel;
   logic            fb_h, u_beats, c_beats;

   // Synchronizer is left unreset so a key held through reset is already visible afterwards.
   always_ff @(posedge CLOCK_50) begin
      key_s1 <= start_n;
      key_s2 <= key_s1;
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         key_db <= 1'b1;
         db_cnt <= '0;
      end else if (key_s2 == key_db) begin
         db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE - 1)) begin
         key_db <= key_s2;
         db_cnt <= '0;
      end else begin
         db_cnt <= db_cnt + DB_W'(1);
      end
   end

   // Press fires in the cycle the debounced level is about to fall.
   assign press = key_db && !key_s2 && (db_cnt == DB_W'(DEBOUNCE - 1));
   assign busy  = (state != IDLE);

   always_comb begin
      com_raw = com_ra;
      if (!fb_h) begin
         case (mode_h)
            2'b01:   com_raw = com_m;
            2'b10:   com_raw = com_re;
            default: com_raw = com_ra;
         endcase
      end
      com_sel = (com_raw == 2'b11) ? 2'b00 : com_raw;
   end

   // 00 rock, 01 scissor, 10 paper
   always_comb begin
      u_beats = (user_loaded == 2'b00 && com_loaded == 2'b01) ||
                (user_loaded == 2'b01 && com_loaded == 2'b10) ||
                (user_loaded == 2'b10 && com_loaded == 2'b00);
      c_beats = (com_loaded == 2'b00 && user_loaded == 2'b01) ||
                (com_loaded == 2'b01 && user_loaded == 2'b10) ||
                (com_loaded == 2'b10 && user_loaded == 2'b00);
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state         <= IDLE;
         user_h        <= 2'b00;
         mode_h        <= 2'b00;
         fb_h          <= 1'b0;
         to_cnt        <= '0;
         com_loaded    <= 2'b00;
         user_loaded   <= 2'b00;
         user_score    <= 8'h00;
         com_score     <= 8'h00;
         uwin          <= 1'b0;
         cwin          <= 1'b0;
         equ           <= 1'b0;
         learn_valid   <= 1'b0;
         draw_start    <= 1'b0;
         fallback      <= 1'b0;
         invalid_press <= 1'b0;
      end else begin
         learn_valid   <= 1'b0;
         draw_start    <= 1'b0;
         invalid_press <= 1'b0;
         case (state)
            IDLE: begin
               if (press) begin
                  user_h <= user;
                  mode_h <= mode;
                  fb_h   <= 1'b0;
                  to_cnt <= '0;
                  if (user == 2'b11)
                     invalid_press <= 1'b1;
                  else if (mode == 2'b10 && !re_ready)
                     state <= WAIT_READY;
                  else
                     state <= LATCH;
               end
            end
            WAIT_READY: begin
               if (re_ready) begin
                  state <= LATCH;
               end else if (to_cnt == TO_W'(READY_TIMEOUT - 1)) begin
                  fb_h  <= 1'b1;
                  state <= LATCH;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
            end
            LATCH: begin
               com_loaded  <= com_sel;
               user_loaded <= user_h;
               uwin        <= 1'b0;
               cwin        <= 1'b0;
               equ         <= 1'b0;
               fallback    <= fb_h;
               state       <= SCORE;
            end
            SCORE: begin
               uwin <= u_beats;
               cwin <= c_beats;
               equ  <= !u_beats && !c_beats;
               if (u_beats && user_score != 8'hFF) user_score <= user_score + 8'd1;
               if (c_beats && com_score != 8'hFF)  com_score  <= com_score + 8'd1;
               learn_valid <= 1'b1;
               draw_start  <= 1'b1;
               state       <= WAIT_DRAW;
            end
            WAIT_DRAW: begin
               if (draw_done) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
